sram_controller: RTL
====================

SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 Parameter WAIT_CYCLES, default 3, number of idle wait states after the two half-word transfers.
REQ-002 Parameter BASE_ADDR, default 1024, byte address of the first data-memory word.
REQ-003 clock  in  1  single system clock, rising-edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 wrEn  in  1  memory-write request from the memory stage.
REQ-006 rdEn  in  1  memory-read request from the memory stage.
REQ-007 address  in  32  byte address of the access (ALU result).
REQ-008 writeData  in  32  word to store.
REQ-009 readData  out  32  last word read; registered.
REQ-010 ready  out  1  high means no access pending; pipeline freezes while low.
REQ-011 SRAM_ADDR  out  18  half-word address to external SRAM.
REQ-012 SRAM_DQ_in  in  16  data bus from SRAM.
REQ-013 SRAM_DQ_out  out  16  data bus to SRAM.
REQ-014 SRAM_DQ_oe  out  1  drive enable for SRAM_DQ_out.
REQ-015 SRAM_WE_N  out  1  active-low write strobe.
REQ-016 SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  tied 0 (always selected, both bytes).

Function
REQ-017 FSM states: IDLE, LOW, HIGH, WAIT, DONE; a request is wrEn|rdEn sampled in IDLE.
REQ-018 IDLE -> LOW on request; LOW -> HIGH; HIGH -> WAIT; WAIT -> DONE after WAIT_CYCLES cycles (counter cleared on entry); DONE -> IDLE unconditionally.
REQ-019 Access type is latched on leaving IDLE; wrEn has priority when both requests are high.
REQ-020 Word offset off = (address - BASE_ADDR) >> 2, modulo 2^17; latched on leaving IDLE.
REQ-021 SRAM_ADDR = {off, 0} in LOW, {off, 1} in HIGH, held at last value otherwise.
REQ-022 Write: SRAM_DQ_out = writeData[15:0] in LOW, writeData[31:16] in HIGH; SRAM_WE_N = 0 and SRAM_DQ_oe = 1 only in those two states.
REQ-023 Read: SRAM_DQ_in captured into readData[15:0] at the edge leaving LOW, into readData[31:16] at the edge leaving HIGH; readData is otherwise held.
REQ-024 ready = 0 when (IDLE with a request) or LOW/HIGH/WAIT; ready = 1 in DONE and in IDLE with no request.
REQ-025 Latency: request first seen in cycle 0 gives ready = 1 in cycle 3 + WAIT_CYCLES (cycle 6 at default).
REQ-026 Request still high in the cycle after DONE starts a new access (back-to-back, one ready-high cycle between accesses).
REQ-027 Request dropped mid-access (flush) does not abort; the access completes through DONE.
REQ-028 Addresses below BASE_ADDR wrap by the modulo rule; no error output.

Reset
REQ-029 reset_n low forces, asynchronously: state IDLE, counter 0, readData 0, SRAM_ADDR 0, SRAM_WE_N 1, SRAM_DQ_oe 0, SRAM_DQ_out 0.
REQ-030 Reset mid-write deasserts SRAM_WE_N immediately; the partial write is not retried.

Structure
REQ-031 State encoding, BASE_ADDR and WAIT_CYCLES defaults live in the shared package with the execute-command constants.
REQ-032 Single flat module; no sub-module. The wait counter is inline, width clog2(WAIT_CYCLES+1).

Verification
REQ-033 Write 0xDEADBEEF to address 1024 -> SRAM half-word 0 = 0xBEEF, 1 = 0xDEAD; WE_N low exactly 2 cycles; ready high in cycle 6.
REQ-034 SRAM model holds 0x1234 at addr 2 and 0x5678 at addr 3; read address 1028 -> readData = 0x56781234 with ready high in cycle 6.
REQ-035 No request for 10 cycles -> ready = 1, SRAM_WE_N = 1, SRAM_DQ_oe = 0 throughout.
REQ-036 reset_n pulsed low while in HIGH of a write -> WE_N = 1 and DQ_oe = 0 in the same cycle; state IDLE; readData = 0.
REQ-037 wrEn and rdEn both high at address 1032 with data 0xA5A5_5A5A -> a write occurs to half-words 4 and 5; readData unchanged.
REQ-038 rdEn held high across two accesses at 1024 then 1028 -> two reads; ready high for exactly one cycle between them (cycle 6, then cycle 13).

Source files
------------

// File: rtl/sram_controller_pkg.sv
// Shared definitions for the data-memory SRAM controller and the execute stage.
package sram_controller_pkg;

  // Access sequencer states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOW  = 3'd1,
    ST_HIGH = 3'd2,
    ST_WAIT = 3'd3,
    ST_DONE = 3'd4
  } sram_state_e;

  // Data memory starts at this byte address; the SRAM sees offsets from it.
  localparam int unsigned SRAM_BASE_ADDR   = 1024;
  // Idle cycles after the two half-word transfers (SRAM recovery time).
  localparam int unsigned SRAM_WAIT_CYCLES = 3;
  // Word-offset width: 2^18 half-words = 2^17 words.
  localparam int unsigned SRAM_OFF_W       = 17;

  // Execute-stage command codes
  localparam logic [3:0] EXE_ADD = 4'd0;
  localparam logic [3:0] EXE_SUB = 4'd2;
  localparam logic [3:0] EXE_AND = 4'd4;
  localparam logic [3:0] EXE_OR  = 4'd5;
  localparam logic [3:0] EXE_NOR = 4'd6;
  localparam logic [3:0] EXE_XOR = 4'd7;
  localparam logic [3:0] EXE_SLA = 4'd8;
  localparam logic [3:0] EXE_SRL = 4'd9;
  localparam logic [3:0] EXE_SRA = 4'd10;
  localparam logic [3:0] EXE_NOP = 4'd15;

  // Word offset of a byte address relative to the data-memory base, wrapping
  // modulo 2^17 so addresses below the base fold to the top of the SRAM.
  function automatic logic [SRAM_OFF_W-1:0] word_offset(input logic [31:0] addr,
                                                        input logic [31:0] base);
    return SRAM_OFF_W'((addr - base) >> 2);
  endfunction

endpackage

// File: rtl/sram_controller.sv
// Data-memory controller: splits each 32-bit access into two 16-bit SRAM
// transfers (low half then high half) followed by a fixed recovery wait,
// holding the pipeline via ready until the access finishes.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = SRAM_WAIT_CYCLES,
  parameter int unsigned BASE_ADDR   = SRAM_BASE_ADDR
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        wrEn,
  input  logic        rdEn,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        ready,
  output logic [17:0] SRAM_ADDR,
  input  logic [15:0] SRAM_DQ_in,
  output logic [15:0] SRAM_DQ_out,
  output logic        SRAM_DQ_oe,
  output logic        SRAM_WE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);

  localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = (WAIT_CYCLES < 1) ? '0 : CNT_W'(WAIT_CYCLES - 1);

  sram_state_e           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  is_wr_q, is_wr_d;
  logic [SRAM_OFF_W-1:0] off_q, off_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [17:0]           addr_q;
  logic                  req;
  logic                  drive;

  assign req = wrEn | rdEn;

  // Chip always selected with both byte lanes enabled
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state: fixed sequence once started; requests only matter in IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (req) state_d = ST_LOW;
      ST_LOW:  state_d = ST_HIGH;
      ST_HIGH: state_d = (WAIT_CYCLES == 0) ? ST_DONE : ST_WAIT;
      ST_WAIT: if (cnt_q == CNT_LAST) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the current state and latched access info
  always_comb begin
    ready       = (state_q == ST_DONE) || ((state_q == ST_IDLE) && !req);
    drive       = is_wr_q && ((state_q == ST_LOW) || (state_q == ST_HIGH));
    SRAM_WE_N   = !drive;
    SRAM_DQ_oe  = drive;
    SRAM_DQ_out = '0;
    if (drive) SRAM_DQ_out = (state_q == ST_LOW) ? writeData[15:0] : writeData[31:16];
    unique case (state_q)
      ST_LOW:  SRAM_ADDR = {off_q, 1'b0};
      ST_HIGH: SRAM_ADDR = {off_q, 1'b1};
      default: SRAM_ADDR = addr_q;
    endcase
  end

  // Datapath next values: latch access on leaving IDLE, capture read halves
  always_comb begin
    cnt_d   = cnt_q;
    is_wr_d = is_wr_q;
    off_d   = off_q;
    rdata_d = rdata_q;
    if (state_q == ST_HIGH)      cnt_d = '0;
    else if (state_q == ST_WAIT) cnt_d = cnt_q + 1'b1;
    if ((state_q == ST_IDLE) && req) begin
      // write wins when both requests are raised
      is_wr_d = wrEn;
      off_d   = word_offset(address, 32'(BASE_ADDR));
    end
    if (!is_wr_q && (state_q == ST_LOW))  rdata_d[15:0]  = SRAM_DQ_in;
    if (!is_wr_q && (state_q == ST_HIGH)) rdata_d[31:16] = SRAM_DQ_in;
  end

  // Datapath registers; SRAM_ADDR is held between transfers via addr_q
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      is_wr_q <= 1'b0;
      off_q   <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      is_wr_q <= is_wr_d;
      off_q   <= off_d;
      rdata_q <= rdata_d;
      addr_q  <= SRAM_ADDR;
    end
  end

  assign readData = rdata_q;

endmodule
